// File: rtl/stopwatch_digit_counter.sv
// Four-digit BCD stopwatch: start/pause/clear FSM, count-tick prescaler,
// BCD digit chain with sticky overflow, and a free-running display scan index.
module stopwatch_digit_counter #(
  parameter int unsigned TICK_DIV = 1000000,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START_STOP,
  input  logic       CLR,
  output logic [3:0] CNT1,
  output logic [3:0] CNT2,
  output logic [3:0] CNT3,
  output logic [3:0] CNT4,
  output logic [1:0] SELECT,
  output logic       RUN,
  output logic       OVF
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tick_q;
  logic [SW-1:0] scan_q;
  logic          clr_evt;
  logic          tick_wrap;

  // Leaving PAUSE for IDLE wipes counts, overflow and the partial tick period.
  assign clr_evt   = (state_q == ST_PAUSE) && CLR;
  assign tick_wrap = (state_q == ST_RUN) && (tick_q == TW'(TICK_DIV - 1));

  // Next-state decode; CLR has priority over START_STOP in PAUSE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (START_STOP) state_d = ST_RUN;
      ST_RUN:   if (START_STOP) state_d = ST_PAUSE;
      ST_PAUSE: begin
        if (CLR)             state_d = ST_IDLE;
        else if (START_STOP) state_d = ST_RUN;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register with RUN flag registered alongside it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      RUN     <= 1'b0;
    end else begin
      state_q <= state_d;
      RUN     <= (state_d == ST_RUN);
    end
  end

  // Tick prescaler: advances only in RUN, holds its phase across a pause.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_q <= '0;
    end else if (clr_evt) begin
      tick_q <= '0;
    end else if (state_q == ST_RUN) begin
      tick_q <= tick_wrap ? '0 : tick_q + TW'(1);
    end
  end

  // BCD ripple increment on each tick; 9999 wraps to 0000 and latches OVF.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CNT1 <= 4'd0;
      CNT2 <= 4'd0;
      CNT3 <= 4'd0;
      CNT4 <= 4'd0;
      OVF  <= 1'b0;
    end else if (clr_evt) begin
      CNT1 <= 4'd0;
      CNT2 <= 4'd0;
      CNT3 <= 4'd0;
      CNT4 <= 4'd0;
      OVF  <= 1'b0;
    end else if (tick_wrap) begin
      if (CNT1 != 4'd9) begin
        CNT1 <= CNT1 + 4'd1;
      end else begin
        CNT1 <= 4'd0;
        if (CNT2 != 4'd9) begin
          CNT2 <= CNT2 + 4'd1;
        end else begin
          CNT2 <= 4'd0;
          if (CNT3 != 4'd9) begin
            CNT3 <= CNT3 + 4'd1;
          end else begin
            CNT3 <= 4'd0;
            if (CNT4 != 4'd9) begin
              CNT4 <= CNT4 + 4'd1;
            end else begin
              CNT4 <= 4'd0;
              OVF  <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Free-running scan prescaler; SELECT steps modulo 4 on each wrap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scan_q <= '0;
      SELECT <= 2'd0;
    end else if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_q <= '0;
      SELECT <= SELECT + 2'd1;
    end else begin
      scan_q <= scan_q + SW'(1);
    end
  end

endmodule

// File: tb/tb_stopwatch_digit_counter.sv
// Scoreboard bench: driver applies stimulus and pushes the reference model's
// expected outputs per edge; a negedge monitor pops and compares.
module tb_stopwatch_digit_counter;

  localparam int unsigned TICK = 4;
  localparam int unsigned SCAN = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START_STOP = 1'b0;
  logic       CLR = 1'b0;
  logic [3:0] CNT1, CNT2, CNT3, CNT4;
  logic [1:0] SELECT;
  logic       RUN, OVF;

  stopwatch_digit_counter #(
    .TICK_DIV(TICK),
    .SCAN_DIV(SCAN)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START_STOP(START_STOP),
    .CLR       (CLR),
    .CNT1      (CNT1),
    .CNT2      (CNT2),
    .CNT3      (CNT3),
    .CNT4      (CNT4),
    .SELECT    (SELECT),
    .RUN       (RUN),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int cnt;
    int sel;
    bit run;
    bit ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: stopwatch as a decimal value plus abstract mode/phase.
  typedef enum int {MIdle, MRun, MPause} mode_t;
  mode_t m_mode;
  int    m_count, m_phase, m_edges;
  bit    m_ovf;

  function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic void model_reset();
    m_mode  = MIdle;
    m_count = 0;
    m_phase = 0;
    m_edges = 0;
    m_ovf   = 1'b0;
  endfunction

  function automatic void model_edge(input bit ss, input bit clr);
    m_edges++;
    if (m_mode == MRun) begin
      m_phase++;
      if (m_phase == TICK) begin
        m_phase = 0;
        m_count = (m_count + 1) % 10000;
        if (m_count == 0) m_ovf = 1'b1;
      end
    end
    case (m_mode)
      MIdle:  if (ss) m_mode = MRun;
      MRun:   if (ss) m_mode = MPause;
      MPause: begin
        if (clr) begin
          m_mode  = MIdle;
          m_count = 0;
          m_ovf   = 1'b0;
          m_phase = 0;
        end else if (ss) begin
          m_mode = MRun;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic step(input bit ss, input bit clr);
    exp_t e;
    START_STOP = ss;
    CLR        = clr;
    @(posedge CLK);
    model_edge(ss, clr);
    e.cnt = m_count;
    e.sel = (m_edges / SCAN) % 4;
    e.run = (m_mode == MRun);
    e.ovf = m_ovf;
    sb.push_back(e);
    #1;
    START_STOP = 1'b0;
    CLR        = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cnt"}, {CNT4, CNT3, CNT2, CNT1}, 16'h0000);
    chk({tag, "_sel"}, 16'(SELECT), 16'd0);
    chk({tag, "_run"}, 16'(RUN), 16'd0);
    chk({tag, "_ovf"}, 16'(OVF), 16'd0);
  endtask

  // Monitor: one expected record per edge, compared half a cycle later.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("cnt", {CNT4, CNT3, CNT2, CNT1}, to_bcd(e.cnt));
      chk("select", 16'(SELECT), 16'(e.sel));
      chk("run", 16'(RUN), 16'(e.run));
      chk("ovf", 16'(OVF), 16'(e.ovf));
    end
  end

  initial begin
    model_reset();
    #3;
    check_all_zero("por");
    @(negedge CLK);
    #2;
    RST = 1'b0;

    // IDLE: CLR is a no-op.
    for (int i = 0; i < 10; i++) step(1'b0, ($urandom_range(0, 2) == 0));

    // Count 40 edges with random (ignored) CLR pulses in RUN.
    step(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, ($urandom_range(0, 3) == 0));
    for (int i = 0; i < 360; i++) step(1'b0, 1'b0);

    // Random start/stop/clear traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));

    // Pause then simultaneous START_STOP+CLR in PAUSE.
    if (m_mode == MIdle) step(1'b1, 1'b0);
    for (int i = 0; i < 23; i++) step(1'b0, 1'b0);
    if (m_mode == MRun) step(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b1);

    // START_STOP exactly on an increment edge.
    step(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 2 * TICK; i++) begin
      if (m_mode == MRun && m_phase == TICK - 1) break;
      step(1'b0, 1'b0);
    end
    step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Run through the 9999 -> 0000 wrap, then on to 0123 with OVF set.
    step(1'b1, 1'b0);
    for (int i = 0; i < 10000 * TICK + 8; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 200 * TICK; i++) begin
      if (m_count == 123) break;
      step(1'b0, 1'b0);
    end
    chk("model_at_0123", 16'(m_count), 16'd123);

    // Asynchronous reset between edges.
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("rst_hold");
    @(negedge CLK);
    #2;
    RST = 1'b0;
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0);

    repeat (2) @(negedge CLK);
    chk("sb_drain", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
